// File: rtl/puf_ctrl_pkg.sv
// Shared types and sizing helpers for the PUF key sequencer.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        SAMPLE,
        RELAX,
        VOTE,
        DONE
    } state_t;

    localparam int NUM_CHALLENGES = 4;
    localparam int RESP_W         = 8;
    localparam int KEY_W          = 32;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/puf_key_ctrl_if.sv
// Request/response and PUF-array signals of the key sequencer.
// The slave side is the sequencer; the master side is its environment.
interface puf_key_ctrl_if;
    import puf_ctrl_pkg::*;

    logic              start;
    logic              abort;
    logic [RESP_W-1:0] puf_response;
    logic              puf_enable;
    logic [1:0]        puf_challenge;
    logic              busy;
    logic              done;
    logic [KEY_W-1:0]  key;
    logic              key_valid;
    logic [KEY_W-1:0]  unstable_mask;

    modport master (
        output start, abort, puf_response,
        input  puf_enable, puf_challenge, busy, done, key, key_valid, unstable_mask
    );

    modport slave (
        input  start, abort, puf_response,
        output puf_enable, puf_challenge, busy, done, key, key_valid, unstable_mask
    );

endinterface

// File: rtl/puf_vote_bank.sv
// Per-bit ones counters for one challenge plus majority and unanimity decode.
module puf_vote_bank
    import puf_ctrl_pkg::*;
#(
    parameter int NUM_EVAL = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc_en,
    input  logic [RESP_W-1:0] response,
    output logic [RESP_W-1:0] vote,
    output logic [RESP_W-1:0] unstable
);

    localparam int CW = cnt_w(NUM_EVAL);
    localparam logic [CW-1:0] HALF = CW'(NUM_EVAL / 2);
    localparam logic [CW-1:0] ALL  = CW'(NUM_EVAL);

    logic [CW-1:0] ones_cnt [RESP_W];

    // Count ones per response bit; clear takes priority over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RESP_W; i++) ones_cnt[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < RESP_W; i++) ones_cnt[i] <= '0;
        end else if (inc_en) begin
            for (int i = 0; i < RESP_W; i++) ones_cnt[i] <= ones_cnt[i] + CW'(response[i]);
        end
    end

    // Majority vote and "not unanimous" flag for each bit.
    always_comb begin
        vote     = '0;
        unstable = '0;
        for (int i = 0; i < RESP_W; i++) begin
            vote[i]     = (ones_cnt[i] > HALF);
            unstable[i] = (ones_cnt[i] != '0) && (ones_cnt[i] != ALL);
        end
    end

endmodule

// File: rtl/puf_key_ctrl.sv
// PUF key sequencer: sweeps the four challenges, evaluates each NUM_EVAL
// times through settle/sample/relax windows and assembles the voted key.
module puf_key_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int RELAX_CYCLES  = 2,
    parameter int NUM_EVAL      = 5
) (
    input logic           clk,
    input logic           rst,
    puf_key_ctrl_if.slave bus
);

    localparam int TMAX = (SETTLE_CYCLES > RELAX_CYCLES) ? SETTLE_CYCLES : RELAX_CYCLES;
    localparam int TW   = cnt_w(TMAX);
    localparam int EW   = cnt_w(NUM_EVAL);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] RELAX_LAST  = TW'(RELAX_CYCLES - 1);
    localparam logic [EW-1:0] EVAL_ALL    = EW'(NUM_EVAL);

    state_t           state, state_d;
    logic [TW-1:0]    timer, timer_d;
    logic [EW-1:0]    eval, eval_d;
    logic [1:0]       chal, chal_d;
    logic [KEY_W-1:0] key_r, key_d;
    logic [KEY_W-1:0] mask_r, mask_d;
    logic             kv_r, kv_d;
    logic             enable_r, busy_r, done_r;
    logic             vote_clr, vote_inc;
    logic [RESP_W-1:0] vote, unstable;

    puf_vote_bank #(.NUM_EVAL(NUM_EVAL)) u_vote (
        .clk      (clk),
        .rst      (rst),
        .clr      (vote_clr),
        .inc_en   (vote_inc),
        .response (bus.puf_response),
        .vote     (vote),
        .unstable (unstable)
    );

    // Next-state, timer, evaluation/challenge counters and key assembly.
    always_comb begin
        state_d  = state;
        timer_d  = '0;
        eval_d   = eval;
        chal_d   = chal;
        key_d    = key_r;
        mask_d   = mask_r;
        kv_d     = kv_r;
        vote_clr = 1'b0;
        vote_inc = 1'b0;
        if (bus.abort) begin
            // Abort beats start and discards any partial or finished result.
            state_d  = IDLE;
            eval_d   = '0;
            chal_d   = '0;
            key_d    = '0;
            mask_d   = '0;
            kv_d     = 1'b0;
            vote_clr = 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_d  = ARM;
                        eval_d   = '0;
                        chal_d   = '0;
                        kv_d     = 1'b0;
                        vote_clr = 1'b1;
                    end
                end
                ARM: begin
                    if (timer == SETTLE_LAST) state_d = SAMPLE;
                    else                      timer_d = timer + 1'b1;
                end
                SAMPLE: begin
                    vote_inc = 1'b1;
                    eval_d   = eval + 1'b1;
                    state_d  = RELAX;
                end
                RELAX: begin
                    if (timer == RELAX_LAST) state_d = (eval == EVAL_ALL) ? VOTE : ARM;
                    else                     timer_d = timer + 1'b1;
                end
                VOTE: begin
                    key_d[{chal, 3'b000} +: RESP_W]  = vote;
                    mask_d[{chal, 3'b000} +: RESP_W] = unstable;
                    vote_clr = 1'b1;
                    eval_d   = '0;
                    if (chal == 2'(NUM_CHALLENGES - 1)) begin
                        state_d = DONE;
                        kv_d    = 1'b1;
                    end else begin
                        // Challenge only moves here, while the array enable is low.
                        chal_d  = chal + 2'd1;
                        state_d = ARM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            eval     <= '0;
            chal     <= '0;
            key_r    <= '0;
            mask_r   <= '0;
            kv_r     <= 1'b0;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_d;
            timer    <= timer_d;
            eval     <= eval_d;
            chal     <= chal_d;
            key_r    <= key_d;
            mask_r   <= mask_d;
            kv_r     <= kv_d;
            enable_r <= (state_d == ARM) || (state_d == SAMPLE);
            busy_r   <= (state_d != IDLE) && (state_d != DONE);
            done_r   <= (state_d == DONE) && (state != DONE);
        end
    end

    assign bus.puf_enable    = enable_r;
    assign bus.puf_challenge = chal;
    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.key           = key_r;
    assign bus.key_valid     = kv_r;
    assign bus.unstable_mask = mask_r;

endmodule
